umai_tx_striper: RTL
====================

# umai_tx_striper

Transmit-side striper between the UMAI master/slave request/response sources and the AIB channel adapters. It accepts one UMAI item per handshake: a write command, read command, write-data beat or read-data beat. It splits the item into 72-bit flits and distributes them round-robin over the contiguous channel range `c_first_chn_id..c_last_chn_id`. Each channel has a 2-entry FIFO so that it drains independently.

## Interface
- `NumChannels`, default 6: number of AIB channels (at most 8).
- `i_clk`  in  1  clock.
- `i_rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `c_first_chn_id`  in  3  first active channel (quasi-static).
- `c_last_chn_id`  in  3  last active channel (quasi-static).
- `i_valid`  in  1  item valid.
- `o_ready`  out  1  item accepted when `i_valid & o_ready`.
- `i_type`  in  2  item type: 00 wcmd, 01 rcmd, 10 wdata, 11 rdata.
- `i_data`  in  512  item payload. For a command, `[31:0]` is addr and `[37:32]` is len; other bits are ignored.
- `o_tx_valid[NumChannels]`  out  1  flit valid per channel.
- `i_tx_ready[NumChannels]`  in  1  flit ready per channel.
- `o_tx_data[NumChannels]`  out  72  flit per channel.
- `o_idle`  out  1  high when the holding register and all FIFOs are empty.

## Operation
- **Config validity:** the config is valid iff `first <= last` and `last < NumChannels`.
  - With an invalid config, `o_ready` = 0 and no pushes occur.
  - Changing the config while `o_idle` = 0 is illegal and the result is undefined.
- **Flit count per item:**
  - Commands (types 00, 01): 1 flit.
  - Data (types 10, 11): 8 flits. Flit k carries `i_data[64k+63:64k]`, k = 0..7.
- **Flit format:**
  - `[71:70]` type.
  - `[69]` last: 1 on the final flit of the item.
  - `[68:66]` k: the flit index.
  - `[65:64]` zero.
  - `[63:0]` payload. A command flit carries `{26'b0, len, addr}`.
- **Storage:** the item is captured into a holding register (`hold_vld`, type, data, flit counter `k`) on accept.
- **States:**
  - IDLE (`hold_vld` = 0).
  - SEND: push flit k to channel `ptr`.
  - A push succeeds when that channel's FIFO count < 2, or when it is 2 and the FIFO pops this cycle.
  - On push, `k` increments and `ptr` advances: `ptr == last` wraps to `first`, otherwise `ptr + 1`.
  - A push of the last flit returns the block to IDLE, unless a new item is accepted in the same cycle.
- **Rotation:** `ptr` persists across items, so the receiver's reassembly order is continuous. If `ptr` lies outside `[first, last]` at push time, it is forced to `first` before use.
- **`o_ready`** = valid config & (`!hold_vld` | a last-flit push succeeding this cycle). This allows back-to-back items.
- **Per-channel FIFO:**
  - 2 entries, in order.
  - `o_tx_valid` = count ≠ 0 and `o_tx_data` = head entry.
  - Pop on `o_tx_valid & i_tx_ready`.
  - Channels outside the active range keep `o_tx_valid` = 0.
- **Stall:** a full target FIFO stalls the striper. Other channels keep draining.
- **Reset** (any time, including mid-item): discards the holding register and all FIFO contents.

## Timing
- Reset values:
  - `o_ready` = 0 while `i_rst_n` = 0; after reset it equals the config validity.
  - `o_tx_valid` = 0 and `o_tx_data` = 0 on all channels.
  - `o_idle` = 1.
  - `ptr` = `c_first_chn_id`.
- Item accepted in cycle T: flit 0 is pushed at the end of T+1 and is visible on `o_tx_valid` in T+2. Flit k is visible in T+2+k when there are no stalls.
- Throughput: at most one push per cycle.
  - A data item occupies 8 push cycles; the next item can be accepted in the cycle of the 8th push.
  - A command item occupies 1 push cycle.
- Push/pop on the same cycle to the same FIFO at count 2 is allowed; the count stays 2.
- Push/pop at count 0 is a normal push; the flit appears the next cycle.
- Signal behaviour under handshake:
  - `o_tx_data` is stable while `o_tx_valid & !i_tx_ready`.
  - `i_data` and `i_type` are sampled only at accept.

## Test plan
- **Single data, channels 0..5, all ready:** rdata item with `i_data` word k = `64'h1111_0000_0000_000k`.
  - Flits appear on channels 0,1,2,3,4,5,0,1 in cycles T+2..T+9, with k = 0..7.
  - The last bit is set only on k = 7; type = 11.
  - `ptr` ends at 2.
- **Commands, first=2, last=3:** wcmd (addr `32'hDEAD_BEEF`, len 5), then rcmd (addr `32'h1000`, len 0), back-to-back.
  - Flit on channel 2 is `{2'b00, 1, 3'd0, 2'b0, 26'b0, 6'd5, 32'hDEADBEEF}`.
  - Next flit is on channel 3 with type 01.
  - `o_ready` stays high every cycle.
- **Backpressure, channels 0..1:** channel 1 `i_tx_ready` = 0 during a wdata item.
  - Channel 1 FIFO fills after 2 flits, the striper stalls, and `o_ready` = 0.
  - Raising ready resumes delivery; the flit order per channel is preserved and no flit is lost or duplicated.
- **Invalid config** (first=4, last=2, or last=6 with NumChannels=6):
  - `o_ready` = 0 with `i_valid` = 1, all `o_tx_valid` = 0 and `o_idle` = 1.
  - Fixing the config restores `o_ready` = 1.
- **Reset mid-item:** assert `i_rst_n` = 0 after 3 flits of a data item.
  - All `o_tx_valid` drop immediately (asynchronously).
  - After release, `ptr` = first and `o_idle` = 1; a new item starts again at k = 0.
- **Full FIFO simultaneous push/pop:** channel 0 count = 2, `i_tx_ready` = 1, and the striper targets channel 0.
  - The push succeeds in the same cycle and the count stays 2.

Source files
------------

// File: rtl/umai_tx_striper_if.sv
// Item and per-channel flit handshake bundle between the UMAI sources,
// the transmit striper and the AIB channel adapters.
interface umai_tx_striper_if #(
  parameter int NumChannels = 6
);
  logic                   i_valid;
  logic                   o_ready;
  logic [1:0]             i_type;
  logic [511:0]           i_data;
  logic [NumChannels-1:0] o_tx_valid;
  logic [NumChannels-1:0] i_tx_ready;
  logic [71:0]            o_tx_data [NumChannels];

  // master: the item source plus the channel sinks; slave: the striper
  modport master (
    output i_valid, i_type, i_data, i_tx_ready,
    input  o_ready, o_tx_valid, o_tx_data
  );

  modport slave (
    input  i_valid, i_type, i_data, i_tx_ready,
    output o_ready, o_tx_valid, o_tx_data
  );
endinterface

// File: rtl/umai_tx_striper.sv
// Splits UMAI items into 72-bit flits and stripes them round-robin over the
// active AIB channel range, with a 2-entry FIFO per channel.
//
// state   | meaning
// ST_IDLE | holding register empty, ready for a new item
// ST_SEND | pushing flit k of the held item to channel ptr
module umai_tx_striper #(
  parameter int NumChannels = 6
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [2:0]         c_first_chn_id,
  input  logic [2:0]         c_last_chn_id,
  umai_tx_striper_if.slave   bus,
  output logic               o_idle
);

  typedef enum logic {ST_IDLE, ST_SEND} state_t;

  state_t       state;
  logic [1:0]   hold_type;
  logic [511:0] hold_data;
  logic [2:0]   k;
  logic [2:0]   ptr;

  logic                   cfg_ok;
  logic [2:0]             ptr_eff;
  logic                   is_cmd;
  logic                   flit_last;
  logic [63:0]            payload;
  logic [71:0]            flit;
  logic                   sel_free;
  logic                   push_ok;
  logic                   last_push;
  logic                   accept;
  logic [NumChannels-1:0] full;
  logic [NumChannels-1:0] pop;
  logic [NumChannels-1:0] push;
  logic [NumChannels-1:0] tx_valid_v;

  assign cfg_ok    = (c_first_chn_id <= c_last_chn_id) &&
                     (int'(c_last_chn_id) < NumChannels);
  // A stale pointer left over from a previous config restarts at first
  assign ptr_eff   = ((ptr < c_first_chn_id) || (ptr > c_last_chn_id)) ?
                     c_first_chn_id : ptr;
  assign is_cmd    = ~hold_type[1];
  assign flit_last = is_cmd | (k == 3'd7);
  assign payload   = is_cmd ? {26'b0, hold_data[37:0]} : hold_data[{k, 6'b0} +: 64];
  assign flit      = {hold_type, flit_last, k, 2'b00, payload};

  always_comb begin
    sel_free = 1'b0;
    for (int c = 0; c < NumChannels; c++) begin
      if (ptr_eff == 3'(c)) sel_free = ~full[c] | pop[c];
    end
  end

  assign push_ok   = (state == ST_SEND) && cfg_ok && sel_free;
  assign last_push = push_ok & flit_last;

  always_comb begin
    push = '0;
    for (int c = 0; c < NumChannels; c++) begin
      push[c] = push_ok && (ptr_eff == 3'(c));
    end
  end

  assign bus.o_ready = i_rst_n & cfg_ok & ((state == ST_IDLE) | last_push);
  assign accept      = bus.i_valid & bus.o_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      hold_type <= 2'b00;
      hold_data <= '0;
      k         <= 3'd0;
      ptr       <= c_first_chn_id;
    end else begin
      if (push_ok) begin
        ptr <= (ptr_eff == c_last_chn_id) ? c_first_chn_id : ptr_eff + 3'd1;
      end
      // An accept coinciding with the last push reloads instead of idling
      if (accept) begin
        state     <= ST_SEND;
        hold_type <= bus.i_type;
        hold_data <= bus.i_data;
        k         <= 3'd0;
      end else if (last_push) begin
        state <= ST_IDLE;
      end else if (push_ok) begin
        k <= k + 3'd1;
      end
    end
  end

  for (genvar c = 0; c < NumChannels; c++) begin : g_chn
    logic [1:0]  cnt;
    logic [71:0] ent0;
    logic [71:0] ent1;

    assign full[c]       = cnt[1];
    assign tx_valid_v[c] = (cnt != 2'd0);
    assign pop[c]        = tx_valid_v[c] & bus.i_tx_ready[c];
    assign bus.o_tx_data[c] = ent0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        cnt  <= 2'd0;
        ent0 <= '0;
        ent1 <= '0;
      end else begin
        case ({push[c], pop[c]})
          2'b10: begin
            if (cnt == 2'd0) ent0 <= flit;
            else             ent1 <= flit;
            cnt <= cnt + 2'd1;
          end
          2'b01: begin
            ent0 <= ent1;
            cnt  <= cnt - 2'd1;
          end
          2'b11: begin
            if (cnt == 2'd1) begin
              ent0 <= flit;
            end else begin
              ent0 <= ent1;
              ent1 <= flit;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.o_tx_valid = tx_valid_v;
  assign o_idle         = (state == ST_IDLE) && (tx_valid_v == '0);

endmodule
